// File: rtl/fc_pkg.sv
// -----------------------------------------------------------------------------
// fc_pkg
// Shared definitions for the fully-connected weight ping-pong buffer:
//   - default geometry parameters (neurons, weights per neuron, slice, width)
//   - shadow-bank fill state enum
//   - addr_width(): slice-index width, never narrower than one bit
// -----------------------------------------------------------------------------
package fc_pkg;

  localparam int N_NEURON_DEF = 10;
  localparam int N_WEIGHT_DEF = 9;
  localparam int SLICE_DEF    = 3;
  localparam int DW_DEF       = 8;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } shadow_state_t;

  function automatic int addr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fc_weight_bank.sv
// -----------------------------------------------------------------------------
// fc_weight_bank
// One weight bank: DEPTH slices, each slice holding SLICE weights for every
// neuron. Synchronous write port, combinational read mux (the caller
// registers the read data). Storage is never reset.
// Ports:
//   i_clk    clock
//   i_we     write enable
//   i_waddr  slice index written
//   i_wdata  slice data written
//   i_raddr  slice index read (out-of-range indices read slice 0; the caller
//            rejects such reads anyway)
//   o_rdata  slice data read
// -----------------------------------------------------------------------------
module fc_weight_bank
  import fc_pkg::*;
#(
  parameter int N_NEURON = N_NEURON_DEF,
  parameter int SLICE    = SLICE_DEF,
  parameter int DW       = DW_DEF,
  parameter int DEPTH    = N_WEIGHT_DEF / SLICE_DEF,
  parameter int AW       = addr_width(DEPTH)
) (
  input  logic                                   i_clk,
  input  logic                                   i_we,
  input  logic [AW-1:0]                          i_waddr,
  input  logic [N_NEURON-1:0][SLICE-1:0][DW-1:0] i_wdata,
  input  logic [AW-1:0]                          i_raddr,
  output logic [N_NEURON-1:0][SLICE-1:0][DW-1:0] o_rdata
);

  logic [N_NEURON-1:0][SLICE-1:0][DW-1:0] r_mem [DEPTH];
  logic [AW-1:0]                          w_ridx;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Keep the mux index inside the array so no X can escape from it.
  assign w_ridx  = ({1'b0, i_raddr} < (AW+1)'(DEPTH)) ? i_raddr : '0;
  assign o_rdata = r_mem[w_ridx];

endmodule

// File: rtl/fc_weight_pingpong_buffer.sv
// -----------------------------------------------------------------------------
// fc_weight_pingpong_buffer
// Two weight banks used ping-pong: the active bank is read by the FC datapath
// while the shadow bank is loaded slice by slice. Once the shadow bank is full
// a swap request exchanges the roles.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_wr_valid/o_wr_ready write handshake into the shadow bank
//   i_wr_data             one slice for every neuron
//   o_shadow_full         shadow bank completely loaded
//   i_swap/o_swap_ack     swap request / one-cycle acknowledge
//   i_rd_en, i_rd_addr    read request and slice index in the active bank
//   o_weight              registered read data (holds when not updated)
//   o_weight_valid        o_weight updated by an accepted read
//   o_rd_err              one-cycle pulse for a rejected read
//   o_active_bank         index of the readable bank
// -----------------------------------------------------------------------------
module fc_weight_pingpong_buffer
  import fc_pkg::*;
#(
  parameter int   N_NEURON = N_NEURON_DEF,
  parameter int   N_WEIGHT = N_WEIGHT_DEF,
  parameter int   SLICE    = SLICE_DEF,
  parameter int   DW       = DW_DEF,
  localparam int  DEPTH    = N_WEIGHT / SLICE,
  localparam int  AW       = addr_width(DEPTH)
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic                                   i_wr_valid,
  output logic                                   o_wr_ready,
  input  logic [N_NEURON-1:0][SLICE-1:0][DW-1:0] i_wr_data,
  output logic                                   o_shadow_full,
  input  logic                                   i_swap,
  output logic                                   o_swap_ack,
  input  logic                                   i_rd_en,
  input  logic [AW-1:0]                          i_rd_addr,
  output logic [N_NEURON-1:0][SLICE-1:0][DW-1:0] o_weight,
  output logic                                   o_weight_valid,
  output logic                                   o_rd_err,
  output logic                                   o_active_bank
);

  if ((N_WEIGHT % SLICE) != 0 || N_WEIGHT < SLICE) begin : g_bad_geometry
    $error("fc_weight_pingpong_buffer: N_WEIGHT must be a non-zero multiple of SLICE");
  end

  shadow_state_t r_state, w_state_next;
  logic [AW-1:0] r_wr_ptr, w_wr_ptr_next;
  logic          r_active_bank;
  logic          r_active_loaded;
  logic          r_swap_ack;
  logic          r_weight_valid;
  logic          r_rd_err;
  logic [N_NEURON-1:0][SLICE-1:0][DW-1:0] r_weight;

  logic          w_wr_accept;
  logic          w_wr_last;
  logic          w_swap_go;
  logic          w_rd_ok;
  logic [N_NEURON-1:0][SLICE-1:0][DW-1:0] w_bank_rdata [2];

  assign o_wr_ready    = (r_state != FULL);
  assign o_shadow_full = (r_state == FULL);
  assign w_wr_accept   = i_wr_valid & o_wr_ready;
  assign w_wr_last     = (r_wr_ptr == AW'(DEPTH - 1));
  // Swap is only honoured once FULL is registered, so a swap in the cycle of
  // the final beat is dropped.
  assign w_swap_go     = i_swap & (r_state == FULL);
  assign w_rd_ok       = r_active_loaded & ({1'b0, i_rd_addr} < (AW+1)'(DEPTH));

  // Shadow fill FSM: next-state logic
  always_comb begin
    w_state_next  = r_state;
    w_wr_ptr_next = r_wr_ptr;
    if (w_wr_accept) begin
      w_wr_ptr_next = w_wr_last ? '0 : r_wr_ptr + 1'b1;
    end
    case (r_state)
      EMPTY: begin
        if (w_wr_accept) begin
          w_state_next = w_wr_last ? FULL : FILLING;
        end
      end
      FILLING: begin
        if (w_wr_accept && w_wr_last) begin
          w_state_next = FULL;
        end
      end
      FULL: begin
        if (w_swap_go) begin
          w_state_next = EMPTY;
        end
      end
      default: w_state_next = EMPTY;
    endcase
  end

  // Shadow fill FSM and bank-role registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= EMPTY;
      r_wr_ptr        <= '0;
      r_active_bank   <= 1'b0;
      r_active_loaded <= 1'b0;
      r_swap_ack      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wr_ptr   <= w_wr_ptr_next;
      r_swap_ack <= w_swap_go;
      if (w_swap_go) begin
        r_active_bank   <= ~r_active_bank;
        r_active_loaded <= 1'b1;
      end
    end
  end

  // Read path: uses the pre-edge active bank, so a read coinciding with a
  // swap still returns the old bank.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_weight       <= '0;
      r_weight_valid <= 1'b0;
      r_rd_err       <= 1'b0;
    end else begin
      r_weight_valid <= 1'b0;
      r_rd_err       <= 1'b0;
      if (i_rd_en) begin
        if (w_rd_ok) begin
          r_weight       <= w_bank_rdata[r_active_bank];
          r_weight_valid <= 1'b1;
        end else begin
          r_rd_err <= 1'b1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    fc_weight_bank #(
      .N_NEURON (N_NEURON),
      .SLICE    (SLICE),
      .DW       (DW),
      .DEPTH    (DEPTH),
      .AW       (AW)
    ) u_bank (
      .i_clk   (i_clk),
      .i_we    (w_wr_accept & (r_active_bank != 1'(gi))),
      .i_waddr (r_wr_ptr),
      .i_wdata (i_wr_data),
      .i_raddr (i_rd_addr),
      .o_rdata (w_bank_rdata[gi])
    );
  end

  assign o_swap_ack     = r_swap_ack;
  assign o_weight       = r_weight;
  assign o_weight_valid = r_weight_valid;
  assign o_rd_err       = r_rd_err;
  assign o_active_bank  = r_active_bank;

endmodule

// File: tb/tb_fc_weight_pingpong_buffer.sv
// -----------------------------------------------------------------------------
// tb_fc_weight_pingpong_buffer
// Directed bench for the weight ping-pong buffer with default geometry
// (10 neurons, 3 slices of 3 weights, 8-bit weights).
// -----------------------------------------------------------------------------
module tb_fc_weight_pingpong_buffer;
  import fc_pkg::*;

  localparam int NN = 10;
  localparam int SL = 3;
  localparam int DW = 8;
  localparam int AW = 2;

  typedef logic [NN-1:0][SL-1:0][DW-1:0] beat_t;

  logic          clk;
  logic          rst_n;
  logic          wr_valid;
  logic          wr_ready;
  beat_t         wr_data;
  logic          shadow_full;
  logic          swap;
  logic          swap_ack;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  beat_t         weight;
  logic          weight_valid;
  logic          rd_err;
  logic          active_bank;

  int n_checks = 0;
  int n_errors = 0;

  fc_weight_pingpong_buffer #(
    .N_NEURON (NN),
    .N_WEIGHT (9),
    .SLICE    (SL),
    .DW       (DW)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_wr_valid     (wr_valid),
    .o_wr_ready     (wr_ready),
    .i_wr_data      (wr_data),
    .o_shadow_full  (shadow_full),
    .i_swap         (swap),
    .o_swap_ack     (swap_ack),
    .i_rd_en        (rd_en),
    .i_rd_addr      (rd_addr),
    .o_weight       (weight),
    .o_weight_valid (weight_valid),
    .o_rd_err       (rd_err),
    .o_active_bank  (active_bank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // weight[n][k] of beat b = base + n + SLICE*b + k
  function automatic beat_t mk_beat(input int base, input int b);
    beat_t v;
    for (int n = 0; n < NN; n++) begin
      for (int k = 0; k < SL; k++) begin
        v[n][k] = DW'(base + n + SL * b + k);
      end
    end
    return v;
  endfunction

  task automatic write_beat(input int base, input int b);
    wr_valid = 1'b1;
    wr_data  = mk_beat(base, b);
    step();
    wr_valid = 1'b0;
  endtask

  task automatic do_swap();
    swap = 1'b1;
    step();
    swap = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    swap     = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = '0;
    step();
    step();

    // Reset state
    check("rst_wr_ready", wr_ready, 1);
    check("rst_shadow_full", shadow_full, 0);
    check("rst_active_bank", active_bank, 0);
    check("rst_weight_zero", (weight == '0), 1);
    check("rst_valid", weight_valid, 0);
    check("rst_swap_ack", swap_ack, 0);
    check("rst_rd_err", rd_err, 0);
    rst_n = 1'b1;
    step();

    // Read before any load is rejected
    rd_en = 1'b1; rd_addr = 2'd0;
    step();
    rd_en = 1'b0;
    check("unloaded_rd_valid", weight_valid, 0);
    check("unloaded_rd_err", rd_err, 1);
    check("unloaded_rd_weight_zero", (weight == '0), 1);
    step();
    check("idle_rd_err_clear", rd_err, 0);

    // Two beats then an early swap: ignored
    write_beat(0, 0);
    check("fill1_wr_ready", wr_ready, 1);
    write_beat(0, 1);
    do_swap();
    check("early_swap_ack", swap_ack, 0);
    check("early_swap_bank", active_bank, 0);
    check("filling_not_full", shadow_full, 0);

    // Third beat with a simultaneous swap: swap dropped, bank now full
    wr_valid = 1'b1; wr_data = mk_beat(0, 2); swap = 1'b1;
    step();
    swap = 1'b0;
    check("last_beat_swap_ack", swap_ack, 0);
    check("last_beat_bank", active_bank, 0);
    check("full_shadow_full", shadow_full, 1);
    check("full_wr_ready", wr_ready, 0);
    // Fourth beat with valid held: must not overwrite slice 0
    wr_data = mk_beat(200, 0);
    step();
    wr_valid = 1'b0;
    check("extra_beat_still_full", shadow_full, 1);

    // Swap while full
    do_swap();
    check("swap1_ack", swap_ack, 1);
    check("swap1_bank", active_bank, 1);
    check("swap1_shadow_empty", shadow_full, 0);
    step();
    check("swap1_ack_pulse", swap_ack, 0);

    // Read slice 2: neuron 4 = {10,11,12}, neuron 9 k2 = 17
    rd_en = 1'b1; rd_addr = 2'd2;
    step();
    rd_en = 1'b0;
    check("rd2_valid", weight_valid, 1);
    check("rd2_n4_k0", weight[4][0], 10);
    check("rd2_n4_k1", weight[4][1], 11);
    check("rd2_n4_k2", weight[4][2], 12);
    check("rd2_n9_k2", weight[9][2], 17);

    // Slice 0 holds beat 0, not the rejected 4th beat
    rd_en = 1'b1; rd_addr = 2'd0;
    step();
    check("rd0_n3_k1", weight[3][1], 4);

    // Out-of-range address
    rd_addr = 2'd3;
    step();
    rd_en = 1'b0;
    check("oob_rd_err", rd_err, 1);
    check("oob_rd_valid", weight_valid, 0);
    check("oob_weight_hold", weight[3][1], 4);

    // Second load (+100) while reading the active bank every cycle
    rd_en = 1'b1;
    for (int b = 0; b < 3; b++) begin
      rd_addr  = AW'(b);
      wr_valid = 1'b1;
      wr_data  = mk_beat(100, b);
      step();
      check($sformatf("bg_rd%0d_valid", b), weight_valid, 1);
      check($sformatf("bg_rd%0d_n0_k0", b), weight[0][0], 64'(3 * b));
    end
    wr_valid = 1'b0;
    check("load2_full", shadow_full, 1);

    // Swap in the same cycle as a read of slice 0: old bank data returned
    rd_addr = 2'd0; swap = 1'b1;
    step();
    swap = 1'b0;
    check("swap2_ack", swap_ack, 1);
    check("swap2_bank", active_bank, 0);
    check("swap2_rd_n0_k0", weight[0][0], 0);
    check("swap2_rd_n0_k1", weight[0][1], 1);
    check("swap2_rd_n0_k2", weight[0][2], 2);
    step();
    rd_en = 1'b0;
    check("post_swap_n0_k0", weight[0][0], 100);
    check("post_swap_n0_k1", weight[0][1], 101);
    check("post_swap_n0_k2", weight[0][2], 102);
    step();
    check("idle_valid_low", weight_valid, 0);
    check("idle_err_low", rd_err, 0);
    check("idle_weight_hold", weight[0][2], 102);

    // Reset in the middle of a third load
    write_beat(50, 0);
    write_beat(50, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_shadow_full", shadow_full, 0);
    check("mid_rst_wr_ready", wr_ready, 1);
    check("mid_rst_bank", active_bank, 0);
    check("mid_rst_weight_zero", (weight == '0), 1);
    step();
    rst_n = 1'b1;
    step();
    rd_en = 1'b1; rd_addr = 2'd0;
    step();
    rd_en = 1'b0;
    check("post_rst_rd_err", rd_err, 1);
    check("post_rst_rd_valid", weight_valid, 0);

    // Full reload into bank 1 and swap makes reads work again
    for (int b = 0; b < 3; b++) write_beat(20, b);
    check("reload_full", shadow_full, 1);
    do_swap();
    check("reload_swap_ack", swap_ack, 1);
    check("reload_bank", active_bank, 1);
    rd_en = 1'b1; rd_addr = 2'd1;
    step();
    rd_en = 1'b0;
    check("reload_rd_valid", weight_valid, 1);
    check("reload_rd_n2_k0", weight[2][0], 25);
    check("reload_rd_n7_k2", weight[7][2], 32);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fc_weight_pingpong_buffer.md
FC_WEIGHT_PINGPONG_BUFFER -- requirements
Module: fc_weight_pingpong_buffer

Interface
REQ-001 Parameter N_NEURON, default 10: number of output neurons served in parallel.
REQ-002 Parameter N_WEIGHT, default 9: weights stored per neuron.
REQ-003 Parameter SLICE, default 3: weights per neuron delivered per read; N_WEIGHT SHALL be a multiple of SLICE (elaboration error otherwise).
REQ-004 Parameter DW, default 8: weight width in bits; derived DEPTH = N_WEIGHT/SLICE, AW = max(1, clog2(DEPTH)).
REQ-005 i_clk  input  1  sole clock; all logic on its rising edge.
REQ-006 i_rst_n  input  1  asynchronous, active-low reset.
REQ-007 i_wr_valid  input  1  write beat offered.
REQ-008 o_wr_ready  output  1  shadow bank can accept a beat.
REQ-009 i_wr_data  input  [N_NEURON][SLICE][DW]  one slice of weights for every neuron.
REQ-010 o_shadow_full  output  1  shadow bank completely loaded.
REQ-011 i_swap  input  1  single-cycle request to exchange active and shadow banks.
REQ-012 o_swap_ack  output  1  one-cycle pulse, swap performed.
REQ-013 i_rd_en  input  1  read request.
REQ-014 i_rd_addr  input  AW  slice index within the active bank.
REQ-015 o_weight  output  [N_NEURON][SLICE][DW]  registered read data.
REQ-016 o_weight_valid  output  1  o_weight valid this cycle.
REQ-017 o_rd_err  output  1  one-cycle pulse, rejected read.
REQ-018 o_active_bank  output  1  index of bank currently readable.

Function
REQ-019 Two banks, each DEPTH x N_NEURON x SLICE x DW; one active (read-only), one shadow (write-only).
REQ-020 Shadow FSM states EMPTY, FILLING, FULL; o_wr_ready = 1 in EMPTY/FILLING, 0 in FULL; o_shadow_full = (state == FULL).
REQ-021 Write handshake: beat accepted when i_wr_valid & o_wr_ready; data stored at shadow slice wr_ptr, wr_ptr increments.
REQ-022 EMPTY -> FILLING on first accepted beat; accepted beat with wr_ptr == DEPTH-1 -> FULL and wr_ptr wraps to 0; if DEPTH == 1 the first beat goes EMPTY -> FULL directly.
REQ-023 i_wr_valid while FULL: ignored, no data change.
REQ-024 i_swap while FULL: next edge flips o_active_bank, sets active_loaded, shadow FSM -> EMPTY, o_swap_ack = 1 for one cycle.
REQ-025 i_swap while not FULL: ignored, no ack, no state change; includes cycle where last beat is accepted (FULL not yet visible).
REQ-026 Read: i_rd_en with active_loaded and i_rd_addr < DEPTH -> o_weight = active bank slice i_rd_addr, o_weight_valid = 1, exactly 1 cycle latency.
REQ-027 Read with !active_loaded or i_rd_addr >= DEPTH: o_weight_valid = 0, o_rd_err = 1 next cycle, o_weight holds previous value.
REQ-028 Read and swap in same cycle: read returns pre-swap active bank data.
REQ-029 o_weight_valid and o_rd_err are 0 in any cycle following i_rd_en = 0; o_weight holds last value.
REQ-030 Back-to-back reads each cycle SHALL be supported at full throughput.

Reset
REQ-031 On i_rst_n low (asynchronous): shadow FSM EMPTY, wr_ptr 0, o_active_bank 0, active_loaded 0, o_weight all zero, o_weight_valid 0, o_swap_ack 0, o_rd_err 0; o_wr_ready 1 and o_shadow_full 0 after reset.
REQ-032 Bank storage contents are not reset; reset mid-fill discards partial load (previously loaded data is unreachable until a new full load and swap).
REQ-033 Reset deassertion is synchronised externally; block takes no action until first edge after release.

Structure
REQ-034 Shared package fc_pkg holds the default parameter values and the shadow FSM state enum (EMPTY, FILLING, FULL).
REQ-035 One sub-module fc_weight_bank (single bank: write port with slice index, registered-free combinational read mux), instantiated twice.

Verification
REQ-036 Reset, then i_rd_en=1 addr 0 -> o_weight_valid 0, o_rd_err 1, o_weight all 0.
REQ-037 Load 3 beats, weight[n][s][k] = n + 3*beat + k, then i_swap -> o_swap_ack pulse, o_active_bank 1; read addr 2 -> next cycle neuron 4 = {10,11,12}, valid 1.
REQ-038 i_swap after only 2 beats -> no ack, o_active_bank unchanged; 3rd beat -> o_shadow_full 1, o_wr_ready 0; 4th beat with valid held -> not accepted.
REQ-039 Second load (values +100) while reading bank 1 each cycle, swap same cycle as read addr 0 -> that read returns neuron 0 = {0,1,2}, following read addr 0 returns {100,101,102}.
REQ-040 Read addr 3 with DEPTH 3 -> o_rd_err 1, valid 0, o_weight unchanged.
REQ-041 Assert i_rst_n low after 2 beats -> o_shadow_full 0, o_wr_ready 1, o_active_bank 0, reads rejected until full reload and swap.
